// File: rtl/trng_collector_if.sv
// Raw TRNG sample stream in, FWFT FIFO read port and occupancy out.
// master drives samples and rd_ready; slave is the collector.
interface trng_collector_if #(
  parameter int DEPTH = 8
);
  logic [7:0]             raw_in;
  logic                   raw_valid;
  logic                   rd_ready;
  logic                   rd_valid;
  logic [7:0]             rd_data;
  logic [$clog2(DEPTH):0] level;

  modport master (output raw_in, raw_valid, rd_ready, input rd_valid, rd_data, level);
  modport slave  (input raw_in, raw_valid, rd_ready, output rd_valid, rd_data, level);
endinterface

// File: rtl/trng_collector.sv
// TRNG collector: repetition-count health test, warm-up discard, FWFT byte FIFO; a push at edge N is readable after N.
// A full FIFO drops samples unless popped that cycle. Optional whitening via TRNG_COLLECT_WHITEN_EN.
module trng_collector #(
  parameter int DEPTH     = 8,
  parameter int REP_LIMIT = 4,
  parameter int WARMUP    = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            fault_clr,
  output logic            fault,
  trng_collector_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int WW = $clog2(WARMUP + 1);
  localparam int RW = $clog2(REP_LIMIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_COLLECT, S_FAULT} state_t;
  state_t state, state_nxt;

  logic [WW-1:0] warm_cnt;
  logic [RW-1:0] rep_cnt, rep_nxt;
  logic [7:0]    last_sample, wr_dat, head;
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] count, remain;
  logic          active, in_warmup, in_collect, start;
  logic          sample, rep_hit, warm_done, pop, push;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Health fault outranks enable=0; enable is ignored once faulted.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (enable) state_nxt = S_WARMUP;
      S_WARMUP:  if (rep_hit) state_nxt = S_FAULT;
                 else if (!enable) state_nxt = S_IDLE;
                 else if (warm_done) state_nxt = S_COLLECT;
      S_COLLECT: if (rep_hit) state_nxt = S_FAULT;
                 else if (!enable) state_nxt = S_IDLE;
      S_FAULT:   if (fault_clr) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    active     = 1'b0;
    in_warmup  = 1'b0;
    in_collect = 1'b0;
    start      = 1'b0;
    fault      = 1'b0;
    unique case (state)
      S_IDLE:    start = enable;
      S_WARMUP:  begin active = 1'b1; in_warmup = 1'b1; end
      S_COLLECT: begin active = 1'b1; in_collect = 1'b1; end
      S_FAULT:   fault = 1'b1;
      default:   ;
    endcase
  end

`ifdef TRNG_COLLECT_WHITEN_EN
  assign wr_dat = bus.raw_in ^ last_sample;
`else
  assign wr_dat = bus.raw_in;
`endif

  assign sample    = active && bus.raw_valid;
  assign rep_nxt   = (bus.raw_in == last_sample) ? rep_cnt + RW'(1) : RW'(1);
  assign rep_hit   = sample && (rep_nxt == RW'(REP_LIMIT));
  assign warm_done = in_warmup && bus.raw_valid && (warm_cnt == WW'(WARMUP - 1));
  assign pop       = bus.rd_valid && bus.rd_ready;
  assign push      = in_collect && bus.raw_valid && !rep_hit && ((count != LW'(DEPTH)) || pop);
  assign remain    = count - LW'(pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      warm_cnt    <= '0;
      rep_cnt     <= '0;
      last_sample <= '0;
    end else if (start) begin
      warm_cnt <= '0;
      rep_cnt  <= '0;
    end else if (sample) begin
      rep_cnt     <= rep_nxt;
      last_sample <= bus.raw_in;
      if (in_warmup) warm_cnt <= warm_cnt + WW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_dat;
  end

  // head is a registered copy of the FIFO front so rd_data never depends on inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else if (rep_hit) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + LW'(push) - LW'(pop);
      if (remain != '0) begin
        if (pop) head <= mem[rd_ptr + PW'(1)];
      end else if (push) begin
        head <= wr_dat;
      end
    end
  end

  assign bus.rd_valid = (count != '0);
  assign bus.rd_data  = head;
  assign bus.level    = count;
endmodule

// File: tb/tb_trng_collector.sv
// Directed bench for trng_collector: queue-based reference model checked every cycle plus literal checks.
module tb_trng_collector;
  localparam int DEPTH = 8, REP_LIMIT = 4, WARMUP = 16;
`ifdef TRNG_COLLECT_WHITEN_EN
  localparam bit WH = 1'b1;
`else
  localparam bit WH = 1'b0;
`endif
  localparam int M_IDLE = 0, M_WARM = 1, M_COLL = 2, M_FAULT = 3;

  logic clk = 1'b0;
  logic reset, enable, fault_clr, fault;
  trng_collector_if #(.DEPTH(DEPTH)) bus();

  trng_collector #(.DEPTH(DEPTH), .REP_LIMIT(REP_LIMIT), .WARMUP(WARMUP)) dut (
    .clk(clk), .reset(reset), .enable(enable), .fault_clr(fault_clr), .fault(fault), .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  bit done = 1'b0;
  logic [7:0] rdlog[$];

  int m_state = M_IDLE, m_warm = 0, m_run = 0;
  logic [7:0] m_last = 8'h00, m_b;
  logic [7:0] m_q[$];
  bit m_hit, m_pop;

  function automatic void chk(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endfunction

  function automatic logic [7:0] wb(input logic [7:0] cur, input logic [7:0] prev);
    return WH ? (cur ^ prev) : cur;
  endfunction

  // Reference model: spec-level states, run length, and a byte queue.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_state = M_IDLE; m_warm = 0; m_run = 0; m_last = 8'h00; m_q.delete();
    end else begin
      m_hit = 1'b0;
      m_pop = (m_q.size() != 0) && bus.rd_ready;
      if (m_pop) void'(m_q.pop_front());
      case (m_state)
        M_IDLE:  if (enable) begin m_state = M_WARM; m_warm = 0; m_run = 0; end
        M_FAULT: if (fault_clr) m_state = M_IDLE;
        default: begin
          if (bus.raw_valid) begin
            m_run  = (bus.raw_in == m_last) ? m_run + 1 : 1;
            m_b    = wb(bus.raw_in, m_last);
            m_last = bus.raw_in;
            if (m_run == REP_LIMIT) begin
              m_hit = 1'b1; m_q.delete(); m_state = M_FAULT;
            end else if (m_state == M_COLL) begin
              if (m_q.size() < DEPTH) m_q.push_back(m_b);
            end else begin
              m_warm++;
            end
          end
          if (!m_hit) begin
            if (!enable) m_state = M_IDLE;
            else if (m_state == M_WARM && m_warm == WARMUP) m_state = M_COLL;
          end
        end
      endcase
    end
  end

  always @(posedge clk) begin
    #2;
    if (!done) begin
      chk("level", int'(bus.level), m_q.size());
      chk("rd_valid", int'(bus.rd_valid), int'(m_q.size() != 0));
      chk("fault", int'(fault), int'(m_state == M_FAULT));
      if (m_q.size() != 0) chk("rd_data", int'(bus.rd_data), int'(m_q[0]));
    end
  end

  // Transfers are logged half a cycle before the edge that completes them.
  always @(negedge clk) begin
    if (!reset && bus.rd_valid && bus.rd_ready) rdlog.push_back(bus.rd_data);
  end

  task automatic step(input bit en, input bit vld, input logic [7:0] d, input bit rdy, input bit clr);
    enable = en; bus.raw_valid = vld; bus.raw_in = d; bus.rd_ready = rdy; fault_clr = clr;
    @(posedge clk); #1;
  endtask

  task automatic chk_log(input string nm, input logic [7:0] first, input int n, input logic [7:0] prev);
    chk({nm, "_count"}, rdlog.size(), n);
    for (int i = 0; i < n && i < rdlog.size(); i++) begin
      logic [7:0] c, p;
      c = first + 8'(i);
      p = (i == 0) ? prev : c - 8'd1;
      chk(nm, int'(rdlog[i]), int'(wb(c, p)));
    end
    rdlog.delete();
  endtask

  task automatic warmup(input logic [7:0] base);
    step(1, 0, 8'h00, 0, 0);
    for (int i = 0; i < WARMUP; i++) step(1, 1, base + 8'(i), 0, 0);
  endtask

  initial begin
    reset = 1'b1; enable = 0; fault_clr = 0;
    bus.raw_valid = 0; bus.raw_in = 8'h00; bus.rd_ready = 0;
    #3;
    chk("rst_level", int'(bus.level), 0);
    chk("rst_rd_valid", int'(bus.rd_valid), 0);
    chk("rst_rd_data", int'(bus.rd_data), 0);
    chk("rst_fault", int'(fault), 0);
    @(posedge clk); #1; reset = 1'b0;

    // 1) incrementing stream, first kept byte is the 17th sample
    step(1, 0, 8'h00, 1, 0);
    for (int i = 1; i <= 16; i++) step(1, 1, 8'(i), 1, 0);
    chk("t1_warmup_empty", int'(bus.level), 0);
    for (int i = 17; i <= 24; i++) step(1, 1, 8'(i), 1, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 8'h00, 1, 0);
    chk("t1_first", rdlog.size() > 0 ? int'(rdlog[0]) : -1, WH ? 'h01 : 'h11);
    chk("t1_second", rdlog.size() > 1 ? int'(rdlog[1]) : -1, WH ? 'h03 : 'h12);
    chk_log("t1", 8'h11, 8, 8'h10);

    // 2) repetition fault on the 4th identical sample
    step(1, 1, 8'h30, 0, 0);
    step(1, 1, 8'h31, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 8'd50, 0, 0);
    chk("t2_level_before", int'(bus.level), 5);
    step(1, 1, 8'd50, 0, 0);
    chk("t2_fault", int'(fault), 1);
    chk("t2_flushed", int'(bus.level), 0);
    chk("t2_rd_valid", int'(bus.rd_valid), 0);
    step(1, 0, 8'h00, 0, 0);
    chk("t2_fault_sticky", int'(fault), 1);
    step(0, 0, 8'h00, 0, 1);
    chk("t2_fault_clr", int'(fault), 0);

    // 3) saturate at DEPTH, extra samples dropped
    warmup(8'h40);
    for (int i = 0; i < 12; i++) step(1, 1, 8'h60 + 8'(i), 0, 0);
    chk("t3_full", int'(bus.level), DEPTH);
    for (int i = 0; i < 10; i++) step(1, 0, 8'h00, 1, 0);
    chk_log("t3", 8'h60, 8, 8'h4F);
    chk("t3_drained", int'(bus.level), 0);

    // 4) full with simultaneous push and pop
    for (int i = 0; i < 8; i++) step(1, 1, 8'h70 + 8'(i), 0, 0);
    for (int i = 8; i < 16; i++) step(1, 1, 8'h70 + 8'(i), 1, 0);
    chk("t4_level_held", int'(bus.level), DEPTH);
    for (int i = 0; i < 10; i++) step(1, 0, 8'h00, 1, 0);
    chk_log("t4", 8'h70, 16, 8'h6B);

    // 5) asynchronous reset mid-collect
    for (int i = 0; i < 5; i++) step(1, 1, 8'h80 + 8'(i), 0, 0);
    chk("t5_level_before", int'(bus.level), 5);
    enable = 0; bus.raw_valid = 0;
    #2 reset = 1'b1;
    #1;
    chk("t5_level", int'(bus.level), 0);
    chk("t5_rd_valid", int'(bus.rd_valid), 0);
    chk("t5_rd_data", int'(bus.rd_data), 0);
    chk("t5_fault", int'(fault), 0);
    @(posedge clk); #1; reset = 1'b0;

    // 6) enable dropped with 3 queued bytes
    warmup(8'h90);
    for (int i = 0; i < 3; i++) step(1, 1, 8'hA0 + 8'(i), 0, 0);
    chk("t6_level", int'(bus.level), 3);
    step(0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 8'hB0 + 8'(i), 0, i == 0);
    chk("t6_no_push", int'(bus.level), 3);
    chk("t6_rd_valid", int'(bus.rd_valid), 1);
    for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 1, 0);
    chk_log("t6", 8'hA0, 3, 8'h9F);

    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
